csi2_raw_unpacker: RTL and testbench
====================================

Name: csi2_raw_unpacker

Overview:
- Sits directly downstream of the CSI-2 `camera` receiver.
- Consumes its 32-bit payload word stream (image_data/image_data_enable plus packet header fields) and unpacks RAW8 (0x2A) and RAW10 (0x2B) long-packet payloads into groups of 4 pixels, 10 bits each.
- Output feeds the line buffer / ISP.
- No backpressure: the block must keep up with one input word per clock.

Parameters:
- RAW8_TYPE, 8'h2A, data type code treated as RAW8
- RAW10_TYPE, 8'h2B, data type code treated as RAW10

Ports:
- clock  input  1  single system clock; all logic on posedge
- reset  input  1  synchronous, active-low; 0 at posedge clears all state
- virtual_channel  input  2  VC of current packet from receiver
- word_count  input  16  payload length in bytes of current packet
- image_data_type  input  8  data type of current packet
- image_data  input  32  payload word; first byte on the wire in [7:0], fourth in [31:24]
- image_data_enable  input  1  image_data valid this cycle
- packet_abort  input  1  pulse; discard any packet in progress
- pixel_data  output  40  4 pixels; pixel 0 in [9:0] … pixel 3 in [39:30]
- pixel_enable  output  1  pixel_data valid (1-cycle pulse per group)
- pixel_virtual_channel  output  2  VC of the emitted group
- pixel_group_index  output  14  group number within packet, 0-based
- type_error  output  1  1-cycle pulse: packet of unsupported type dropped
- length_error  output  1  1-cycle pulse: packet ended with leftover bytes

Behaviour:
- Reset (reset==0 at posedge): every output 0, state IDLE, byte buffer empty, counters 0.
- States: IDLE, RAW8, RAW10, DROP.
- IDLE + image_data_enable:
  - Latch word_count, virtual_channel, image_data_type.
  - Go to RAW8/RAW10 by type, else DROP with type_error pulsed the next cycle.
  - This first word is processed as payload in the same cycle; it is not lost.
- Byte accounting:
  - bytes_rx counts accepted bytes.
  - A word contributes min(4, word_count − bytes_rx) bytes; excess high bytes of the final word are ignored.
  - When bytes_rx reaches word_count, the state returns to IDLE after that word.
- RAW8:
  - Each accepted full word yields one group on the next cycle.
  - pixel i = {byte i, 2'b00}.
  - A partial final word (1–3 bytes) produces no group and pulses length_error.
- RAW10 packing:
  - Groups of 5 bytes: B0..B3 are the 8 MSBs of P0..P3; B4 holds the LSBs.
  - B4[1:0]→P0, [3:2]→P1, [5:4]→P2, [7:6]→P3.
  - Pixel = {Bn, lsb pair}.
- RAW10 buffering:
  - 8-byte byte buffer with a fill count of 0–8.
  - Each cycle: append accepted bytes, and if fill ≥ 5 (counting bytes appended this cycle), emit one group registered on the next cycle and shift out 5 bytes.
  - Max fill after consume is 3, so the buffer never overflows and at most one group is emitted per cycle.
  - Latency: 1 cycle from the word that completes a group to pixel_enable.
  - A buffer ending with a nonzero fill at packet end is cleared, and length_error is pulsed on the cycle after the last word.
- pixel_group_index:
  - Increments after each emitted group.
  - Cleared on entry to RAW8/RAW10.
  - Wraps modulo 2^14.
- pixel_virtual_channel = latched VC.
- DROP: consume words, no pixel output, return to IDLE at word_count.
- word_count == 0: latch, pulse nothing, go straight back to IDLE (for RAW8/RAW10/DROP type errors still pulse).
- packet_abort:
  - Highest priority after reset: clears the buffer and counters, state→IDLE.
  - A group already registered this cycle still appears; no error pulse.
  - Any image_data_enable in the same cycle is ignored.
- image_data_enable low mid-packet: hold state; gaps are allowed.
- Back-to-back packets: a new packet may start the cycle after the last word of the previous one.

Test Plan:
- RAW8, word_count 8, words 0x44332211, 0x88776655 → two pulses:
  - pixel_data {0x110,0x0CC,0x088,0x044} (P3..P0).
  - Then {0x220,0x1DC,0x198,0x154}.
  - index 0, 1; no errors.
- RAW10, word_count 10, words 0x78563412, 0x3412_??E4 style stream: bytes 12 34 56 78 E4 12 34 56 78 E4 →
  - group 0 P0..P3 = 0x048, 0x0D1, 0x15A, 0x1E3, emitted 1 cycle after word 2.
  - group 1 identical, after word 3 (2 valid bytes).
- Type 0x18, word_count 8 → type_error single pulse, no pixel_enable, back to IDLE, next RAW8 packet unpacks correctly.
- RAW10, word_count 7 → one group, then length_error pulse; buffer empty afterward.
- reset low for 1 cycle mid RAW10 packet (after 1 word) → all outputs 0 next cycle; a following fresh RAW10 packet decodes from group index 0.
- packet_abort mid RAW8 packet, then immediately a new packet with VC 2 → pixel_virtual_channel 2, index restarts at 0.

Source files
------------

// File: rtl/csi2_raw_unpacker_if.sv
// ============================================================================
// csi2_raw_unpacker_if : receiver payload stream in, 4-pixel groups out
// Rev 1.0
// ============================================================================
`default_nettype none

interface csi2_raw_unpacker_if;
    logic [1:0]  virtual_channel;
    logic [15:0] word_count;
    logic [7:0]  image_data_type;
    logic [31:0] image_data;
    logic        image_data_enable;
    logic        packet_abort;
    logic [39:0] pixel_data;
    logic        pixel_enable;
    logic [1:0]  pixel_virtual_channel;
    logic [13:0] pixel_group_index;
    logic        type_error;
    logic        length_error;

    modport master (
        output virtual_channel, word_count, image_data_type, image_data,
               image_data_enable, packet_abort,
        input  pixel_data, pixel_enable, pixel_virtual_channel,
               pixel_group_index, type_error, length_error
    );

    modport slave (
        input  virtual_channel, word_count, image_data_type, image_data,
               image_data_enable, packet_abort,
        output pixel_data, pixel_enable, pixel_virtual_channel,
               pixel_group_index, type_error, length_error
    );
endinterface

`default_nettype wire

// File: rtl/csi2_raw_unpacker.sv
// ============================================================================
// csi2_raw_unpacker : unpacks CSI-2 RAW8/RAW10 payload words into 4x10b groups
// Rev 1.0
// ============================================================================
`default_nettype none

module csi2_raw_unpacker #(
    parameter logic [7:0] RAW8_TYPE  = 8'h2A,
    parameter logic [7:0] RAW10_TYPE = 8'h2B
) (
    input  wire logic           clock,
    input  wire logic           reset,
    csi2_raw_unpacker_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RAW8  = 2'd1,
        S_RAW10 = 2'd2,
        S_DROP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] wc_q, wc_d;
    logic [15:0] bytes_q, bytes_d;
    logic [1:0]  vc_q, vc_d;
    logic [63:0] buf_q, buf_d;
    logic [2:0]  fill_q, fill_d;
    logic [13:0] gidx_q, gidx_d;
    logic [39:0] pix_q, pix_d;
    logic        pen_q, pen_d;
    logic [1:0]  pvc_q, pvc_d;
    logic [13:0] pidx_q, pidx_d;
    logic        te_q, te_d;
    logic        le_q, le_d;

    logic        accept, start, last, emit;
    state_t      mode;
    logic [15:0] eff_wc, eff_bytes, remaining, bytes_next;
    logic [1:0]  eff_vc;
    logic [13:0] gcnt;
    logic [2:0]  eff_fill, nbytes, fill_after;
    logic [3:0]  fill_sum;
    logic [63:0] eff_buf, combined;
    logic [31:0] masked;
    logic [39:0] grp, px8, px10;

    always_comb begin
        accept = bus.image_data_enable && !bus.packet_abort;
        start  = accept && (state_q == S_IDLE);
        if (!start)
            mode = state_q;
        else if (bus.image_data_type == RAW8_TYPE)
            mode = S_RAW8;
        else if (bus.image_data_type == RAW10_TYPE)
            mode = S_RAW10;
        else
            mode = S_DROP;

        // The first word of a packet is processed against the live header.
        eff_wc    = start ? bus.word_count      : wc_q;
        eff_vc    = start ? bus.virtual_channel : vc_q;
        eff_bytes = start ? 16'd0  : bytes_q;
        eff_fill  = start ? 3'd0   : fill_q;
        eff_buf   = start ? 64'd0  : buf_q;
        gcnt      = start ? 14'd0  : gidx_q;

        remaining  = eff_wc - eff_bytes;
        nbytes     = (remaining >= 16'd4) ? 3'd4 : remaining[2:0];
        bytes_next = eff_bytes + {13'd0, nbytes};
        last       = (bytes_next == eff_wc);

        case (nbytes)
            3'd1:    masked = {24'd0, bus.image_data[7:0]};
            3'd2:    masked = {16'd0, bus.image_data[15:0]};
            3'd3:    masked = {8'd0, bus.image_data[23:0]};
            3'd4:    masked = bus.image_data;
            default: masked = 32'd0;
        endcase

        combined   = eff_buf | ({32'd0, masked} << {eff_fill, 3'b000});
        fill_sum   = {1'b0, eff_fill} + {1'b0, nbytes};
        grp        = combined[39:0];
        px10       = {grp[31:24], grp[39:38], grp[23:16], grp[37:36],
                      grp[15:8],  grp[35:34], grp[7:0],   grp[33:32]};
        px8        = {bus.image_data[31:24], 2'b00, bus.image_data[23:16], 2'b00,
                      bus.image_data[15:8],  2'b00, bus.image_data[7:0],   2'b00};
        emit       = 1'b0;
        fill_after = fill_sum[2:0];

        state_d = state_q;
        wc_d    = wc_q;
        bytes_d = bytes_q;
        vc_d    = vc_q;
        buf_d   = buf_q;
        fill_d  = fill_q;
        gidx_d  = gidx_q;
        pix_d   = pix_q;
        pen_d   = 1'b0;
        pvc_d   = pvc_q;
        pidx_d  = pidx_q;
        te_d    = 1'b0;
        le_d    = 1'b0;

        if (bus.packet_abort) begin
            state_d = S_IDLE;
            bytes_d = 16'd0;
            buf_d   = 64'd0;
            fill_d  = 3'd0;
            gidx_d  = 14'd0;
        end else if (accept) begin
            if (start) begin
                wc_d = bus.word_count;
                vc_d = bus.virtual_channel;
                te_d = (mode == S_DROP);
            end
            gidx_d  = gcnt;
            bytes_d = last ? 16'd0 : bytes_next;
            state_d = last ? S_IDLE : mode;

            if (mode == S_RAW8) begin
                emit  = (nbytes == 3'd4);
                pix_d = emit ? px8 : pix_q;
                le_d  = last && (nbytes != 3'd4) && (nbytes != 3'd0);
            end else if (mode == S_RAW10) begin
                emit = (fill_sum >= 4'd5);
                if (emit) begin
                    pix_d      = px10;
                    fill_after = fill_sum[2:0] - 3'd5;
                    buf_d      = combined >> 40;
                end else begin
                    buf_d = combined;
                end
                fill_d = fill_after;
                // Leftover bytes at packet end cannot form a group; flush them.
                if (last) begin
                    le_d   = (fill_after != 3'd0);
                    buf_d  = 64'd0;
                    fill_d = 3'd0;
                end
            end

            if (emit) begin
                pen_d  = 1'b1;
                pvc_d  = eff_vc;
                pidx_d = gcnt;
                gidx_d = gcnt + 14'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
            wc_q    <= 16'd0;
            bytes_q <= 16'd0;
            vc_q    <= 2'd0;
            buf_q   <= 64'd0;
            fill_q  <= 3'd0;
            gidx_q  <= 14'd0;
            pix_q   <= 40'd0;
            pen_q   <= 1'b0;
            pvc_q   <= 2'd0;
            pidx_q  <= 14'd0;
            te_q    <= 1'b0;
            le_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            wc_q    <= wc_d;
            bytes_q <= bytes_d;
            vc_q    <= vc_d;
            buf_q   <= buf_d;
            fill_q  <= fill_d;
            gidx_q  <= gidx_d;
            pix_q   <= pix_d;
            pen_q   <= pen_d;
            pvc_q   <= pvc_d;
            pidx_q  <= pidx_d;
            te_q    <= te_d;
            le_q    <= le_d;
        end
    end

    assign bus.pixel_data            = pix_q;
    assign bus.pixel_enable          = pen_q;
    assign bus.pixel_virtual_channel = pvc_q;
    assign bus.pixel_group_index     = pidx_q;
    assign bus.type_error            = te_q;
    assign bus.length_error          = le_q;

endmodule

`default_nettype wire

// File: tb/tb_csi2_raw_unpacker.sv
// ============================================================================
// tb_csi2_raw_unpacker : directed stimulus with queued expectations and monitor
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_csi2_raw_unpacker;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    csi2_raw_unpacker_if u ();

    csi2_raw_unpacker #(
        .RAW8_TYPE  (8'h2A),
        .RAW10_TYPE (8'h2B)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (u)
    );

    typedef struct packed {
        logic        pe;
        logic        te;
        logic        le;
        logic [39:0] px;
        logic [1:0]  vc;
        logic [13:0] idx;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [1:0]  cur_vc;
    logic [15:0] cur_wc;
    logic [7:0]  cur_dt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t grp(input logic [9:0] p0, input logic [9:0] p1,
                                 input logic [9:0] p2, input logic [9:0] p3,
                                 input logic [1:0] vc, input logic [13:0] idx,
                                 input logic le);
        exp_t e;
        e.pe  = 1'b1;
        e.te  = 1'b0;
        e.le  = le;
        e.px  = {p3, p2, p1, p0};
        e.vc  = vc;
        e.idx = idx;
        return e;
    endfunction

    function automatic exp_t err(input logic te, input logic le);
        exp_t e;
        e     = '0;
        e.te  = te;
        e.le  = le;
        return e;
    endfunction

    always @(negedge clock) begin
        if (reset && (u.pixel_enable || u.type_error || u.length_error)) begin
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_output: pe=%0b te=%0b le=%0b px=0x%0h expected no output",
                         u.pixel_enable, u.type_error, u.length_error, u.pixel_data);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("pixel_enable", {63'd0, u.pixel_enable}, {63'd0, e.pe});
                chk("type_error",   {63'd0, u.type_error},   {63'd0, e.te});
                chk("length_error", {63'd0, u.length_error}, {63'd0, e.le});
                if (e.pe) begin
                    chk("pixel_data", {24'd0, u.pixel_data}, {24'd0, e.px});
                    chk("pixel_vc",   {62'd0, u.pixel_virtual_channel}, {62'd0, e.vc});
                    chk("group_index", {50'd0, u.pixel_group_index}, {50'd0, e.idx});
                end
            end
        end
    end

    task automatic hdr(input logic [1:0] vc, input logic [15:0] wc, input logic [7:0] dt);
        cur_vc = vc;
        cur_wc = wc;
        cur_dt = dt;
    endtask

    task automatic send(input logic [31:0] d);
        @(negedge clock);
        u.virtual_channel   = cur_vc;
        u.word_count        = cur_wc;
        u.image_data_type   = cur_dt;
        u.image_data        = d;
        u.image_data_enable = 1'b1;
        u.packet_abort      = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(negedge clock);
            u.image_data_enable = 1'b0;
            u.packet_abort      = 1'b0;
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_pixel_data"},   {24'd0, u.pixel_data}, 64'd0);
        chk({tag, "_pixel_enable"}, {63'd0, u.pixel_enable}, 64'd0);
        chk({tag, "_pixel_vc"},     {62'd0, u.pixel_virtual_channel}, 64'd0);
        chk({tag, "_group_index"},  {50'd0, u.pixel_group_index}, 64'd0);
        chk({tag, "_type_error"},   {63'd0, u.type_error}, 64'd0);
        chk({tag, "_length_error"}, {63'd0, u.length_error}, 64'd0);
    endtask

    initial begin
        u.virtual_channel   = 2'd0;
        u.word_count        = 16'd0;
        u.image_data_type   = 8'd0;
        u.image_data        = 32'd0;
        u.image_data_enable = 1'b0;
        u.packet_abort      = 1'b0;
        hdr(2'd0, 16'd0, 8'd0);

        repeat (2) @(negedge clock);
        check_all_zero("reset");
        reset = 1'b1;
        gap(1);

        // RAW8, two full words
        hdr(2'd0, 16'd8, 8'h2A);
        q.push_back(grp(10'h044, 10'h088, 10'h0CC, 10'h110, 2'd0, 14'd0, 1'b0));
        send(32'h44332211);
        q.push_back(grp(10'h154, 10'h198, 10'h1DC, 10'h220, 2'd0, 14'd1, 1'b0));
        send(32'h88776655);
        gap(2);

        // RAW10, 10 bytes; high bytes of the final word are beyond word_count
        hdr(2'd1, 16'd10, 8'h2B);
        send(32'h78563412);
        q.push_back(grp(10'h048, 10'h0D1, 10'h15A, 10'h1E3, 2'd1, 14'd0, 1'b0));
        send(32'h563412E4);
        q.push_back(grp(10'h048, 10'h0D1, 10'h15A, 10'h1E3, 2'd1, 14'd1, 1'b0));
        send(32'hDEADE478);
        gap(2);

        // Unsupported type, then a RAW8 packet starting back-to-back
        hdr(2'd0, 16'd8, 8'h18);
        q.push_back(err(1'b1, 1'b0));
        send(32'hCAFEBABE);
        send(32'h01234567);
        hdr(2'd3, 16'd4, 8'h2A);
        q.push_back(grp(10'h004, 10'h008, 10'h00C, 10'h010, 2'd3, 14'd0, 1'b0));
        send(32'h04030201);
        gap(2);

        // Zero-length unsupported packet still flags the type, then RAW8 works
        hdr(2'd0, 16'd0, 8'h30);
        q.push_back(err(1'b1, 1'b0));
        send(32'h12345678);
        hdr(2'd0, 16'd4, 8'h2A);
        q.push_back(grp(10'h3FC, 10'h000, 10'h200, 10'h004, 2'd0, 14'd0, 1'b0));
        send(32'h018000FF);
        gap(2);

        // RAW10 with 7 bytes: one group plus leftover bytes in the same cycle
        hdr(2'd2, 16'd7, 8'h2B);
        send(32'h78563412);
        q.push_back(grp(10'h048, 10'h0D1, 10'h15A, 10'h1E3, 2'd2, 14'd0, 1'b1));
        send(32'hFF3412E4);
        // A following 5-byte packet only decodes right if the buffer was flushed
        hdr(2'd2, 16'd5, 8'h2B);
        send(32'h04030201);
        q.push_back(grp(10'h004, 10'h008, 10'h00C, 10'h010, 2'd2, 14'd0, 1'b0));
        send(32'h00000000);
        gap(2);

        // Reset in the middle of a RAW10 packet
        hdr(2'd1, 16'd10, 8'h2B);
        send(32'h78563412);
        @(negedge clock);
        u.image_data_enable = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        check_all_zero("midreset");
        reset = 1'b1;
        hdr(2'd1, 16'd5, 8'h2B);
        send(32'h78563412);
        q.push_back(grp(10'h048, 10'h0D1, 10'h15A, 10'h1E3, 2'd1, 14'd0, 1'b0));
        send(32'h000000E4);
        gap(2);

        // Abort mid RAW8 packet, then a new packet on VC 2
        hdr(2'd0, 16'd12, 8'h2A);
        q.push_back(grp(10'h044, 10'h088, 10'h0CC, 10'h110, 2'd0, 14'd0, 1'b0));
        send(32'h44332211);
        q.push_back(grp(10'h154, 10'h198, 10'h1DC, 10'h220, 2'd0, 14'd1, 1'b0));
        send(32'h88776655);
        @(negedge clock);
        u.packet_abort      = 1'b1;
        u.image_data_enable = 1'b1;
        u.image_data        = 32'hFFFFFFFF;
        hdr(2'd2, 16'd4, 8'h2A);
        q.push_back(grp(10'h028, 10'h0A8, 10'h128, 10'h1A8, 2'd2, 14'd0, 1'b0));
        send(32'h6A4A2A0A);
        gap(4);

        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
